// File: rtl/seg7_frame_monitor_if.sv
// seg7_frame_monitor_if
//   Groups the observed 7-segment bus and the recovered frame stream into one
//   bundle.
//   Parameter: PERIOD_W sets the width of frame_period. It must match the
//   PERIOD_W of the monitor instance.
//   Modports:
//     master: drives segments and observes the recovered frame information
//             (bench or display side).
//     slave : the monitor; it samples segments and drives all frame outputs.
//   Signals:
//     segments      [6:0]      segment bus {g,f,e,d,c,b,a}, active-high
//     frame_valid              one-cycle pulse when a frame is accepted
//     frame_pattern [6:0]      last accepted pattern
//     frame_digit   [3:0]      hex value of frame_pattern (0 if unknown)
//     digit_known              frame_pattern is a hex glyph
//     frame_period  [PERIOD_W] cycles between the last two frame_valid pulses
//     period_valid             pulse with frame_valid when frame_period updated
//     period_sat               latest frame_period saturated
//     frame_count   [7:0]      accepted frames, mod 256
interface seg7_frame_monitor_if #(
  parameter int unsigned PERIOD_W = 24
);
  logic [6:0]          segments;
  logic                frame_valid;
  logic [6:0]          frame_pattern;
  logic [3:0]          frame_digit;
  logic                digit_known;
  logic [PERIOD_W-1:0] frame_period;
  logic                period_valid;
  logic                period_sat;
  logic [7:0]          frame_count;

  modport master (
    output segments,
    input  frame_valid, frame_pattern, frame_digit, digit_known,
    input  frame_period, period_valid, period_sat, frame_count
  );

  modport slave (
    input  segments,
    output frame_valid, frame_pattern, frame_digit, digit_known,
    output frame_period, period_valid, period_sat, frame_count
  );
endinterface

// File: rtl/seg7_frame_monitor.sv
// seg7_frame_monitor
//   Watches a 7-segment output bus and recovers the displayed frame stream.
//   The bus is registered once. A pattern becomes a frame after STABLE_CYCLES
//   identical samples. A short excursion that returns to the current frame is
//   discarded as a glitch. Each accepted frame is decoded to a hex digit. The
//   monitor counts frames and measures the spacing between frame pulses.
//
//   Parameters:
//     STABLE_CYCLES  identical samples needed to accept a frame (1..255)
//     PERIOD_W       width of the period counter and frame_period
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset
//     mon    seg7_frame_monitor_if.slave (segments in, frame info out)
//   Build option:
//     SEG7_MON_BLANK_FILTER_EN  when defined, the all-off pattern 7'h00 is
//     never a candidate. A blink animation then reports the period of the
//     lit glyph.
module seg7_frame_monitor #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned PERIOD_W      = 24
) (
  input logic                 clk,
  input logic                 reset,
  seg7_frame_monitor_if.slave mon
);

`ifdef SEG7_MON_BLANK_FILTER_EN
  localparam logic BLANK_FILTER = 1'b1;
`else
  localparam logic BLANK_FILTER = 1'b0;
`endif

  // A candidate is accepted on the sample that would bring the count to
  // STABLE_CYCLES.
  localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } state_e;

  state_e              state_q, state_d;
  logic [6:0]          seg_q;
  logic [6:0]          cand_q, cand_d;
  logic [7:0]          stab_q, stab_d;
  logic [6:0]          pattern_q, pattern_d;
  logic [3:0]          digit_q, digit_d;
  logic                known_q, known_d;
  logic                fvalid_q, fvalid_d;
  logic                pvalid_q, pvalid_d;
  logic                sat_q, sat_d;
  logic [7:0]          count_q, count_d;
  logic                have_q, have_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;

  logic                accept;
  logic                load;
  logic                blank;
  logic [6:0]          acc_pat;

  // Returns {known, digit}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    r = '0;
    case (p)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h7C: r = {1'b1, 4'hB};
      7'h39: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Input stage. This register carries no state, so it keeps sampling during
  // reset. The first candidate after reset is then the pattern already on
  // the bus.
  always_ff @(posedge clk) begin
    seg_q <= mon.segments;
  end

  // Frame acquisition FSM: next state, candidate and stability count.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    stab_d  = stab_q;
    accept  = 1'b0;
    load    = 1'b0;
    acc_pat = cand_q;
    blank   = BLANK_FILTER && (seg_q == '0);

    case (state_q)
      IDLE: begin
        if (!blank) load = 1'b1;
      end
      SETTLE: begin
        if (!blank) begin
          if (seg_q == cand_q) begin
            if (stab_q == STAB_LAST) begin
              accept  = 1'b1;
              state_d = LOCKED;
            end else begin
              stab_d = stab_q + 8'd1;
            end
          end else if (have_q && (seg_q == pattern_q)) begin
            state_d = LOCKED;
          end else begin
            load = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (!blank && (seg_q != pattern_q)) load = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Start a new candidate. A single-sample threshold accepts it at once.
    if (load) begin
      cand_d = seg_q;
      stab_d = 8'd1;
      if (STABLE_CYCLES == 1) begin
        accept  = 1'b1;
        acc_pat = seg_q;
        state_d = LOCKED;
      end else begin
        state_d = SETTLE;
      end
    end
  end

  // Frame outputs and period measurement.
  always_comb begin
    pattern_d = pattern_q;
    digit_d   = digit_q;
    known_d   = known_q;
    count_d   = count_q;
    have_d    = have_q;
    period_d  = period_q;
    sat_d     = sat_q;
    fvalid_d  = accept;
    pvalid_d  = accept && have_q;
    // The period counter saturates at all ones and never wraps.
    pcnt_d    = (&pcnt_q) ? pcnt_q : pcnt_q + PERIOD_W'(1);

    if (accept) begin
      pattern_d          = acc_pat;
      {known_d, digit_d} = decode(acc_pat);
      count_d            = count_q + 8'd1;
      have_d             = 1'b1;
      pcnt_d             = PERIOD_W'(1);
      // The first frame after reset has no predecessor to measure from.
      if (have_q) begin
        period_d = pcnt_q;
        sat_d    = &pcnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      stab_q    <= '0;
      pattern_q <= '0;
      digit_q   <= '0;
      known_q   <= 1'b0;
      fvalid_q  <= 1'b0;
      pvalid_q  <= 1'b0;
      sat_q     <= 1'b0;
      count_q   <= '0;
      have_q    <= 1'b0;
      pcnt_q    <= '0;
      period_q  <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      stab_q    <= stab_d;
      pattern_q <= pattern_d;
      digit_q   <= digit_d;
      known_q   <= known_d;
      fvalid_q  <= fvalid_d;
      pvalid_q  <= pvalid_d;
      sat_q     <= sat_d;
      count_q   <= count_d;
      have_q    <= have_d;
      pcnt_q    <= pcnt_d;
      period_q  <= period_d;
    end
  end

  assign mon.frame_valid   = fvalid_q;
  assign mon.frame_pattern = pattern_q;
  assign mon.frame_digit   = digit_q;
  assign mon.digit_known   = known_q;
  assign mon.frame_period  = period_q;
  assign mon.period_valid  = pvalid_q;
  assign mon.period_sat    = sat_q;
  assign mon.frame_count   = count_q;

endmodule

// File: tb/tb_seg7_frame_monitor.sv
// Testbench for seg7_frame_monitor. It uses STABLE_CYCLES=4 and PERIOD_W=8.
// The expected frame stream comes from when each pattern change is driven.
// A pattern driven right after edge N and held is expected to give a frame
// pulse on edge N+1+STABLE_CYCLES. It must be held for at least
// STABLE_CYCLES cycles and must differ from the current frame.
module tb_seg7_frame_monitor;
  localparam int unsigned S    = 4;
  localparam int unsigned PW   = 8;
  localparam int unsigned PMAX = (1 << PW) - 1;
`ifdef SEG7_MON_BLANK_FILTER_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]   cyc;
    logic [6:0]    pat;
    logic [3:0]    dig;
    logic          known;
    logic [PW-1:0] period;
    logic          pvalid;
    logic          sat;
    logic [7:0]    count;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  frame_t      exp_q[$];
  frame_t      obs_q[$];

  // Reference model state
  logic          have_cur;
  logic [6:0]    cur;
  logic          have_last;
  int unsigned   last_edge;
  logic [PW-1:0] last_period;
  logic          last_sat;
  logic [7:0]    exp_count;
  logic [6:0]    glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_frame_monitor_if #(.PERIOD_W(PW)) bus ();

  seg7_frame_monitor #(
    .STABLE_CYCLES(S),
    .PERIOD_W(PW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mon(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Records every pulse, stamped with the index of the edge that caused it.
  task automatic monitor();
    frame_t o;
    forever begin
      @(negedge clk);
      if (bus.frame_valid !== 1'b0 || bus.period_valid !== 1'b0) begin
        o.cyc    = cyc;
        o.pat    = bus.frame_pattern;
        o.dig    = bus.frame_digit;
        o.known  = bus.digit_known;
        o.period = bus.frame_period;
        o.pvalid = bus.period_valid;
        o.sat    = bus.period_sat;
        o.count  = bus.frame_count;
        obs_q.push_back(o);
      end
    end
  endtask

  task automatic expect_frame(input logic [6:0] p, input int unsigned e);
    frame_t      f;
    int unsigned dt;
    f.cyc   = e;
    f.pat   = p;
    f.known = 1'b0;
    f.dig   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (glyph[i] == p) begin
        f.known = 1'b1;
        f.dig   = 4'(i);
      end
    end
    exp_count = exp_count + 8'd1;
    f.count   = exp_count;
    if (have_last) begin
      dt          = e - last_edge;
      last_sat    = (dt >= PMAX);
      last_period = last_sat ? PW'(PMAX) : PW'(dt);
      f.pvalid    = 1'b1;
    end else begin
      f.pvalid = 1'b0;
    end
    f.period  = last_period;
    f.sat     = last_sat;
    have_last = 1'b1;
    last_edge = e;
    have_cur  = 1'b1;
    cur       = p;
    exp_q.push_back(f);
  endtask

  task automatic hold(input logic [6:0] p, input int unsigned n);
    int unsigned start;
    start        = cyc;
    bus.segments = p;
    if (n >= S && !(BLANK_EN && p == 7'h00) && !(have_cur && p == cur))
      expect_frame(p, start + 1 + S);
    step(n);
  endtask

  task automatic release_reset(input logic [6:0] p);
    int unsigned r;
    r           = cyc;
    reset       = 1'b0;
    have_cur    = 1'b0;
    have_last   = 1'b0;
    last_period = '0;
    last_sat    = 1'b0;
    exp_count   = '0;
    // The FSM leaves IDLE on the first edge after reset unless a blank is held.
    if (!(BLANK_EN && p == 7'h00)) expect_frame(p, r + S);
  endtask

  task automatic test_reset();
    bus.segments = 7'h3F;
    reset        = 1'b1;
    step(2);
    checks++;
    if ({bus.frame_valid, bus.frame_pattern, bus.frame_digit, bus.digit_known, bus.frame_period,
         bus.period_valid, bus.period_sat, bus.frame_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got fv=%b pat=%h dig=%h known=%b period=%0d pv=%b sat=%b cnt=%0d, required all 0",
               bus.frame_valid, bus.frame_pattern, bus.frame_digit, bus.digit_known,
               bus.frame_period, bus.period_valid, bus.period_sat, bus.frame_count);
    end
    release_reset(7'h3F);
    step(20);
    step(S + 4);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      frame_t e, o;
      checks++;
      if (exp_q.size() == 0) begin
        o = obs_q.pop_front();
        errors++;
        $display("FAIL reset_extra_frame: got cyc=%0d pat=%h, required none", o.cyc, o.pat);
      end else if (obs_q.size() == 0) begin
        e = exp_q.pop_front();
        errors++;
        $display("FAIL reset_missing_frame: got none, required cyc=%0d pat=%h", e.cyc, e.pat);
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL reset_frame: got cyc=%0d pat=%h dig=%h known=%b period=%0d pv=%b sat=%b cnt=%0d, required cyc=%0d pat=%h dig=%h known=%b period=%0d pv=%b sat=%b cnt=%0d",
                   o.cyc, o.pat, o.dig, o.known, o.period, o.pvalid, o.sat, o.count,
                   e.cyc, e.pat, e.dig, e.known, e.period, e.pvalid, e.sat, e.count);
        end
      end
    end
  endtask

  task automatic test_alternate();
    for (int k = 0; k < 2; k++) begin
      hold(7'h06, 100);
      hold(7'h5B, 100);
    end
    step(S + 4);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      frame_t e, o;
      checks++;
      if (exp_q.size() == 0) begin
        o = obs_q.pop_front();
        errors++;
        $display("FAIL alternate_extra_frame: got cyc=%0d pat=%h, required none", o.cyc, o.pat);
      end else if (obs_q.size() == 0) begin
        e = exp_q.pop_front();
        errors++;
        $display("FAIL alternate_missing_frame: got none, required cyc=%0d pat=%h", e.cyc, e.pat);
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL alternate_frame: got cyc=%0d pat=%h dig=%h known=%b period=%0d pv=%b sat=%b cnt=%0d, required cyc=%0d pat=%h dig=%h known=%b period=%0d pv=%b sat=%b cnt=%0d",
                   o.cyc, o.pat, o.dig, o.known, o.period, o.pvalid, o.sat, o.count,
                   e.cyc, e.pat, e.dig, e.known, e.period, e.pvalid, e.sat, e.count);
        end
      end
    end
  endtask

  task automatic test_glitch();
    hold(7'h4F, 50);
    hold(7'h7F, 3);    // too short, returns to the locked frame
    hold(7'h4F, 47);
    checks++;
    if (bus.frame_count !== exp_count) begin
      errors++;
      $display("FAIL glitch_count: got %0d, required %0d", bus.frame_count, exp_count);
    end
    hold(7'h66, 2);    // too short, replaced by another new pattern
    hold(7'h6D, 100);
    step(S + 4);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      frame_t e, o;
      checks++;
      if (exp_q.size() == 0) begin
        o = obs_q.pop_front();
        errors++;
        $display("FAIL glitch_extra_frame: got cyc=%0d pat=%h, required none", o.cyc, o.pat);
      end else if (obs_q.size() == 0) begin
        e = exp_q.pop_front();
        errors++;
        $display("FAIL glitch_missing_frame: got none, required cyc=%0d pat=%h", e.cyc, e.pat);
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL glitch_frame: got cyc=%0d pat=%h dig=%h known=%b period=%0d pv=%b sat=%b cnt=%0d, required cyc=%0d pat=%h dig=%h known=%b period=%0d pv=%b sat=%b cnt=%0d",
                   o.cyc, o.pat, o.dig, o.known, o.period, o.pvalid, o.sat, o.count,
                   e.cyc, e.pat, e.dig, e.known, e.period, e.pvalid, e.sat, e.count);
        end
      end
    end
  endtask

  task automatic test_saturate();
    hold(7'h3F, 300);  // next period 300 -> saturates
    hold(7'h06, 254);  // next period 254 -> below saturation
    hold(7'h5B, 255);  // next period 255 -> exactly all ones
    hold(7'h06, 20);
    step(S + 4);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      frame_t e, o;
      checks++;
      if (exp_q.size() == 0) begin
        o = obs_q.pop_front();
        errors++;
        $display("FAIL saturate_extra_frame: got cyc=%0d pat=%h, required none", o.cyc, o.pat);
      end else if (obs_q.size() == 0) begin
        e = exp_q.pop_front();
        errors++;
        $display("FAIL saturate_missing_frame: got none, required cyc=%0d pat=%h", e.cyc, e.pat);
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL saturate_frame: got cyc=%0d pat=%h dig=%h known=%b period=%0d pv=%b sat=%b cnt=%0d, required cyc=%0d pat=%h dig=%h known=%b period=%0d pv=%b sat=%b cnt=%0d",
                   o.cyc, o.pat, o.dig, o.known, o.period, o.pvalid, o.sat, o.count,
                   e.cyc, e.pat, e.dig, e.known, e.period, e.pvalid, e.sat, e.count);
        end
      end
    end
  endtask

  task automatic test_reset_mid_settle();
    hold(7'h4F, 2);    // reset lands while 4F is still settling
    reset = 1'b1;
    step(1);
    checks++;
    if ({bus.frame_valid, bus.frame_pattern, bus.frame_digit, bus.digit_known, bus.frame_period,
         bus.period_valid, bus.period_sat, bus.frame_count} !== '0) begin
      errors++;
      $display("FAIL mid_settle_reset_outputs: got fv=%b pat=%h dig=%h known=%b period=%0d pv=%b sat=%b cnt=%0d, required all 0",
               bus.frame_valid, bus.frame_pattern, bus.frame_digit, bus.digit_known,
               bus.frame_period, bus.period_valid, bus.period_sat, bus.frame_count);
    end
    release_reset(7'h4F);
    hold(7'h4F, 20);
    hold(7'h06, 30);
    step(S + 4);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      frame_t e, o;
      checks++;
      if (exp_q.size() == 0) begin
        o = obs_q.pop_front();
        errors++;
        $display("FAIL mid_settle_extra_frame: got cyc=%0d pat=%h, required none", o.cyc, o.pat);
      end else if (obs_q.size() == 0) begin
        e = exp_q.pop_front();
        errors++;
        $display("FAIL mid_settle_missing_frame: got none, required cyc=%0d pat=%h", e.cyc, e.pat);
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL mid_settle_frame: got cyc=%0d pat=%h dig=%h known=%b period=%0d pv=%b sat=%b cnt=%0d, required cyc=%0d pat=%h dig=%h known=%b period=%0d pv=%b sat=%b cnt=%0d",
                   o.cyc, o.pat, o.dig, o.known, o.period, o.pvalid, o.sat, o.count,
                   e.cyc, e.pat, e.dig, e.known, e.period, e.pvalid, e.sat, e.count);
        end
      end
    end
  endtask

  task automatic test_blank();
    int unsigned exp_p;
    hold(7'h3F, 50);
    hold(7'h00, 50);
    hold(7'h3F, 50);
    hold(7'h00, 50);
    // Restart from a blank display so the first lit glyph begins a new
    // sequence.
    bus.segments = 7'h00;
    reset        = 1'b1;
    step(2);
    release_reset(7'h00);
    hold(7'h00, 10);
    hold(7'h3F, 50);
    hold(7'h00, 50);
    hold(7'h06, 30);
    exp_p = BLANK_EN ? 100 : 50;
    checks++;
    if (bus.frame_period !== PW'(exp_p)) begin
      errors++;
      $display("FAIL blank_period: got %0d, required %0d", bus.frame_period, exp_p);
    end
    step(S + 4);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      frame_t e, o;
      checks++;
      if (exp_q.size() == 0) begin
        o = obs_q.pop_front();
        errors++;
        $display("FAIL blank_extra_frame: got cyc=%0d pat=%h, required none", o.cyc, o.pat);
      end else if (obs_q.size() == 0) begin
        e = exp_q.pop_front();
        errors++;
        $display("FAIL blank_missing_frame: got none, required cyc=%0d pat=%h", e.cyc, e.pat);
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL blank_frame: got cyc=%0d pat=%h dig=%h known=%b period=%0d pv=%b sat=%b cnt=%0d, required cyc=%0d pat=%h dig=%h known=%b period=%0d pv=%b sat=%b cnt=%0d",
                   o.cyc, o.pat, o.dig, o.known, o.period, o.pvalid, o.sat, o.count,
                   e.cyc, e.pat, e.dig, e.known, e.period, e.pvalid, e.sat, e.count);
        end
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.segments = 7'h3F;
    have_cur     = 1'b0;
    cur          = '0;
    have_last    = 1'b0;
    last_edge    = 0;
    last_period  = '0;
    last_sat     = 1'b0;
    exp_count    = '0;
    step(2);
    fork
      monitor();
    join_none
    test_reset();
    test_alternate();
    test_glitch();
    test_saturate();
    test_reset_mid_settle();
    test_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
